// File: rtl/fv_bank_cntl_pkg.sv
// Shared definitions for the feature-vector bank controllers: bank geometry,
// request/response structs between the FV memory controller, the banks and
// the PEs, and the word-counter width helper.
package fv_bank_cntl_pkg;

    // Bank geometry, shared with the FV memory controller / router.
    localparam int FV_info_bank_width = 10;
    localparam int Num_Banks_FV       = 4;

    // Words per feature vector and datapath widths used by default.
    localparam int FV_LEN_DEFAULT = 4;
    localparam int PE_TAG_WIDTH   = 2;
    localparam int FV_DATA_WIDTH  = 16;
    localparam int FV_ADDR_WIDTH  = FV_info_bank_width - 2;

    // Routed request from the FV memory controller into one bank controller.
    typedef struct packed {
        logic                     valid;
        logic [PE_TAG_WIDTH-1:0]  PE_tag;
        logic [FV_ADDR_WIDTH-1:0] FV_Bank_addr;
    } FV_MEM_CNTL2FV_Bank_CNTL;

    // Word stream from a bank controller towards the PEs.
    typedef struct packed {
        logic                     valid;
        logic [PE_TAG_WIDTH-1:0]  PE_tag;
        logic [FV_DATA_WIDTH-1:0] data;
        logic                     last;
    } FV_Bank_CNTL2PE;

    // Word counter width: clog2 of the vector length, never less than 1 bit.
    function automatic int fv_cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/fv_bank_cntl.sv
// Per-bank feature-vector read controller. Takes a single-cycle routed
// request, reads FV_LEN consecutive words from its SRAM bank (one read in
// flight at a time) and streams them to the PE side under valid/ready,
// tagged with the requesting PE.
module fv_bank_cntl
    import fv_bank_cntl_pkg::*;
#(
    parameter int ADDR_W = FV_ADDR_WIDTH,
    parameter int DATA_W = FV_DATA_WIDTH,
    parameter int TAG_W  = PE_TAG_WIDTH,
    parameter int FV_LEN = FV_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid,
    input  logic [TAG_W-1:0]  req_PE_tag,
    input  logic [ADDR_W-1:0] req_Bank_addr,
    output logic              Bank_busy,
    output logic              req_err,

    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_PE_tag,
    output logic              out_last
);

    localparam int CNT_W = fv_cnt_width(FV_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FV_LEN - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_SEND = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [TAG_W-1:0]  tag_q;
    logic [ADDR_W-1:0] base_q;

    // Sequencer: one read, one capture, then hold the word until the PE side
    // takes it. Reads are only issued from RD, which is only entered once the
    // previous word has been handed off, so backpressure cannot drop data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tag_q     <= '0;
            base_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        tag_q  <= req_PE_tag;
                        base_q <= req_Bank_addr;
                        cnt    <= '0;
                        state  <= S_RD;
                    end
                end
                S_RD: begin
                    state <= S_CAP;
                end
                S_CAP: begin
                    out_data  <= mem_rdata;
                    out_valid <= 1'b1;
                    out_last  <= (cnt == CNT_LAST);
                    state     <= S_SEND;
                end
                S_SEND: begin
                    // out_valid is always 1 here, so ready alone is the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state <= S_IDLE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_RD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sticky error: a request that lands while a vector is in flight is dropped
    // and flagged until reset.
    always_ff @(posedge clk) begin
        if (reset)
            req_err <= 1'b0;
        else if (req_valid && (state != S_IDLE))
            req_err <= 1'b1;
    end

    // Busy includes the incoming strobe so the router sees the bank taken in
    // the same cycle it routes to it.
    always_comb begin
        Bank_busy  = req_valid | (state != S_IDLE);
        mem_ren    = (state == S_RD);
        mem_addr   = base_q + ADDR_W'(cnt);
        out_PE_tag = tag_q;
    end

endmodule

// File: tb/tb_fv_bank_cntl.sv
// Directed bench for fv_bank_cntl: stimulus pushes expected words into a
// scoreboard queue, an independent monitor pops and compares on every
// output handshake. Cycle-exact checks cover busy/ren/valid timing.
module tb_fv_bank_cntl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_PE_tag;
    logic [7:0]  req_Bank_addr;
    logic        Bank_busy;
    logic        req_err;
    logic        mem_ren;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_PE_tag;
    logic        out_last;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  tag;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_hs   = 0;
    int          ren_cnt = 0;
    logic [15:0] mem [256];

    always #5 clk = ~clk;

    fv_bank_cntl dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_PE_tag    (req_PE_tag),
        .req_Bank_addr (req_Bank_addr),
        .Bank_busy     (Bank_busy),
        .req_err       (req_err),
        .mem_ren       (mem_ren),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_PE_tag    (out_PE_tag),
        .out_last      (out_last)
    );

    // SRAM model: data valid the cycle after the read enable.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_ren) ren_cnt++;
        if (!reset && out_valid && out_ready) begin
            n_hs++;
            if (sb.size() == 0) begin
                chk("unexpected_word", {out_data, 2'b00, out_PE_tag, 3'b000, out_last}, 32'hffff_ffff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("word", {out_data, 2'b00, out_PE_tag, 3'b000, out_last},
                            {e.data,   2'b00, e.tag,      3'b000, e.last});
            end
        end
    end

    // One-cycle request; when accept is set the four expected words are queued.
    task automatic pulse(input logic [1:0] tag, input logic [7:0] addr, input bit accept);
        @(posedge clk); #1;
        req_valid = 1'b1; req_PE_tag = tag; req_Bank_addr = addr;
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                exp_t e;
                logic [7:0] a;
                a = addr + 8'(i);
                e.data = 16'h0100 + {8'h00, a};
                e.tag  = tag;
                e.last = (i == 3);
                sb.push_back(e);
            end
        end
        @(negedge clk);
        chk("busy_in_req_cycle", {31'b0, Bank_busy}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!Bank_busy) begin ok = 1'b1; break; end
        end
        chk(name, {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        chk(name, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        for (int a = 0; a < 256; a++) mem[a] = 16'h0100 + 16'(a);
        reset = 1'b1; req_valid = 1'b0; req_PE_tag = '0; req_Bank_addr = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {24'b0, Bank_busy, req_err, mem_ren, out_valid, out_last, 1'b0, out_PE_tag}, 32'd0);
        chk("reset_data_addr", {out_data, mem_addr, 8'b0}, 32'd0);
        @(posedge clk); #1; reset = 1'b0;

        // Basic vector with exact cycle timing.
        pulse(2'd2, 8'h10, 1'b1);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            chk($sformatf("busy_t+%0d", k), {31'b0, Bank_busy}, {31'b0, (k <= 12)});
            chk($sformatf("valid_t+%0d", k), {31'b0, out_valid},
                {31'b0, (k % 3 == 0) && (k >= 3) && (k <= 12)});
            chk($sformatf("ren_t+%0d", k), {31'b0, mem_ren}, {31'b0, (k % 3 == 1) && (k <= 10)});
        end
        chk("basic_sb_empty", sb.size(), 0);
        chk("hold_after_last", {out_data, 7'b0, out_last, 6'b0, out_PE_tag}, {16'h0113, 8'h01, 8'h02});

        // Backpressure on word 1 for five cycles.
        r0 = ren_cnt;
        pulse(2'd2, 8'h10, 1'b1);
        wait_valid("stall_word0_valid");
        @(posedge clk); #1; out_ready = 1'b0;
        wait_valid("stall_word1_valid");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("stall_hold_%0d", i),
                {out_data, 3'b0, out_valid, 3'b0, out_last, 6'b0, out_PE_tag},
                {16'h0111, 4'h1, 4'h0, 8'h02});
        end
        @(posedge clk); #1; out_ready = 1'b1;
        wait_idle("stall_idle");
        chk("stall_ren_count", ren_cnt - r0, 4);
        chk("stall_sb_empty", sb.size(), 0);

        // Address wrap at the top of the bank.
        pulse(2'd3, 8'hFE, 1'b1);
        wait_idle("wrap_idle");
        chk("wrap_sb_empty", sb.size(), 0);
        chk("wrap_no_err", {31'b0, req_err}, 32'd0);

        // Second request while busy is dropped and flagged.
        pulse(2'd2, 8'h10, 1'b1);
        repeat (2) @(posedge clk);
        pulse(2'd1, 8'h40, 1'b0);
        wait_idle("err_idle");
        chk("err_sticky", {31'b0, req_err}, 32'd1);
        chk("err_sb_empty", sb.size(), 0);
        repeat (3) @(negedge clk);
        chk("err_still_set", {31'b0, req_err}, 32'd1);

        // Reset in the middle of a vector.
        pulse(2'd2, 8'h10, 1'b1);
        repeat (3) @(posedge clk);
        @(posedge clk); #1; reset = 1'b1;
        sb.delete();
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("midreset_outputs",
            {24'b0, Bank_busy, req_err, mem_ren, out_valid, out_last, 1'b0, out_PE_tag}, 32'd0);
        chk("midreset_data_addr", {out_data, mem_addr, 8'b0}, 32'd0);
        pulse(2'd1, 8'h20, 1'b1);
        wait_idle("postreset_idle");
        chk("postreset_sb_empty", sb.size(), 0);
        chk("postreset_no_err", {31'b0, req_err}, 32'd0);

        // Back-to-back requests right after busy falls.
        pulse(2'd2, 8'h30, 1'b1);
        wait_idle("b2b_first_idle");
        pulse(2'd3, 8'h80, 1'b1);
        wait_idle("b2b_second_idle");
        chk("b2b_sb_empty", sb.size(), 0);
        chk("b2b_no_err", {31'b0, req_err}, 32'd0);

        chk("total_handshakes", n_hs, 29);
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fv_bank_cntl.md
# fv_bank_cntl

Per-bank feature-vector read controller; one instance per FV SRAM bank (`Num_Banks_FV` instances). Accepts a single-cycle routed request (valid, PE tag, bank-local address) from the FV memory controller, drives that bank's `Bank_busy` bit back to the router, and reads `FV_LEN` consecutive SRAM words. Streams those words to the PE side with a valid/ready handshake, tagged with the requesting PE.

## Interface
- `ADDR_W`, 8: bank-local word address width; equals `FV_info_bank_width-2`.
- `DATA_W`, 16: SRAM word width.
- `TAG_W`, 2: PE tag width.
- `FV_LEN`, 4: words per feature vector; ≥1.
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `req_valid`  in  1: request strobe, one cycle per request.
- `req_PE_tag`  in  TAG_W: requesting PE.
- `req_Bank_addr`  in  ADDR_W: base word address.
- `Bank_busy`  out  1: bank cannot take a new request.
- `req_err`  out  1: sticky protocol error, request arrived while busy.
- `mem_ren`  out  1: SRAM read enable.
- `mem_addr`  out  ADDR_W: SRAM read address.
- `mem_rdata`  in  DATA_W: SRAM data, valid exactly 1 cycle after `mem_ren`.
- `out_valid`  out  1: output word valid.
- `out_ready`  in  1: PE side accepts the word.
- `out_data`  out  DATA_W: feature word.
- `out_PE_tag`  out  TAG_W: tag of the current request.
- `out_last`  out  1: final word of the vector.

## Operation
- States: IDLE, RD, CAP, SEND.
- IDLE + `req_valid`: latch tag and base address, clear word counter `cnt`, go to RD.
- RD: `mem_ren`=1, `mem_addr`=base+`cnt` (mod 2^ADDR_W; wraps 255→0 at default width), go to CAP.
- CAP: register `mem_rdata` into `out_data`; set `out_valid`=1; set `out_last`=(`cnt`==FV_LEN-1); go to SEND.
- SEND: hold all outputs stable until `out_valid && out_ready`.
  - On handshake with last word: clear `out_valid`, go to IDLE.
  - On handshake otherwise: `cnt`+1, clear `out_valid`, go to RD.
- `Bank_busy` = `req_valid` | (state≠IDLE), combinational. Including `req_valid` covers the router's back-to-back Route check in the same cycle the request lands.
- `req_valid` while state≠IDLE:
  - Request is dropped.
  - In-flight vector is unaffected.
  - `req_err` is set and stays 1 until reset.
- `out_PE_tag` holds the latched tag from request accept until the next request.
- `out_data` and `out_last` hold their values after the last handshake. Only `out_valid` qualifies them.
- `cnt` width is clog2(FV_LEN) with a minimum of 1 bit.

## Timing
- Reset values: every output 0, state IDLE, `cnt`=0, latched tag/addr 0.
- Reset mid-vector: next cycle is IDLE with `out_valid`=0 and `mem_ren`=0. Remaining words are abandoned and no output is emitted for them.
- Request at cycle t: `mem_ren` at t+1, `mem_rdata` sampled at t+2, `out_valid` first high at t+3.
- With `out_ready` held high: one word every 3 cycles. The last handshake of a request at t is at t+3·FV_LEN. IDLE (`Bank_busy`=0) follows at t+3·FV_LEN+1.
- At most one SRAM read is outstanding. A read is never issued while `out_valid`=1, so backpressure cannot lose data.
- `out_valid` never drops without a handshake, except on reset.

## Structure
- Shared package (`sys_defs.svh`):
  - Existing `FV_MEM_CNTL2FV_Bank_CNTL` struct (valid, PE_tag, FV_Bank_addr) drives the `req_*` ports.
  - New `FV_Bank_CNTL2PE` struct: valid, PE_tag, data, last.
  - New `FV_LEN` define.
  - `FV_info_bank_width`, `Num_Banks_FV` are already defined there.
- No sub-module. The SRAM macro is instantiated outside, beside this block. The state enum is local.

## Test plan
- Request tag=2, addr=0x10, `out_ready`=1, SRAM preloaded mem[a]=a+0x100 → words 0x110, 0x111, 0x112, 0x113 at t+3, t+6, t+9, t+12; `out_last` only on 0x113; tag=2 on all; `Bank_busy` high t…t+12, low at t+13.
- Same request with `out_ready` low for 5 cycles on word 1 → 0x111 held stable all 5 cycles; exactly one `mem_ren` per word (4 total); no duplicate or lost words.
- addr=0xFE → reads 0xFE, 0xFF, 0x00, 0x01 (wrap).
- Second request (tag=1) pulsed at t+4 of a running vector → dropped; `req_err`=1 until reset; original 4 words complete with tag=2.
- Reset asserted at t+5 of a vector → next cycle all outputs 0; a new request after reset completes normally with `req_err`=0.
- Back-to-back: new request one cycle after `Bank_busy` falls → `Bank_busy` high in the request cycle; both vectors correct; `req_err` stays 0.
